// File: rtl/codificador_pkg.sv
// Shared types and helpers for the sequential priority encoder.
package codificador_pkg;

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} estado_t;

  localparam logic [7:0] PERDIDOS_MAX = 8'd255;

  // Bit count over a zero-extended request vector (N <= 64).
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + 7'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/busca_prioridade.sv
// Combinational winner search: highest set index (mode=0) or first set bit
// at or above pointer with wrap-around (mode=1).
module busca_prioridade #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vector,
  input  logic [W-1:0] pointer,
  input  logic         mode,
  output logic [W-1:0] index,
  output logic         found
);

  logic [W-1:0] idx;

  always_comb begin
    index = '0;
    idx   = '0;
    found = |vector;
    if (mode) begin
      // Walk offsets downward so the smallest offset from pointer wins last.
      for (int off = N - 1; off >= 0; off--) begin
        idx = pointer + W'(off);
        if (vector[idx]) index = idx;
      end
    end else begin
      for (int i = 0; i < N; i++)
        if (vector[i]) index = W'(i);
    end
  end

endmodule

// File: rtl/codificador_prioridade.sv
// Sequential N-to-log2(N) priority encoder with sticky pending requests,
// valid/ready presentation and a saturating dropped-request counter.
module codificador_prioridade
  import codificador_pkg::*;
#(
  parameter  int N           = 8,
  parameter  bit ROUND_ROBIN = 1'b0,
  localparam int W           = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] d,
  input  logic         ready,
  output logic [W-1:0] y,
  output logic         valid,
  output logic [N-1:0] pendentes,
  output logic [7:0]   perdidos
);

  estado_t      state, state_next;
  logic         hs, load_y, found;
  logic [N-1:0] clr, cap, pend_next, drop, cand;
  logic [W-1:0] ptr, ptr_busca, sel;
  logic [9:0]   soma;

  assign hs        = valid & ready;
  assign clr       = hs ? (N'(1) << y) : '0;
  assign cap       = enable ? d : '0;
  assign pend_next = (pendentes & ~clr) | cap;
  assign drop      = cap & pendentes & ~clr;
  assign soma      = 10'(perdidos) + 10'(popcount(64'(drop)));

  // On a handshake the next winner is picked from the post-clear vector and
  // the round-robin search already starts past the code being consumed.
  assign cand      = (state == PRESENT) ? pend_next : pendentes;
  assign ptr_busca = hs ? y + W'(1) : ptr;

  busca_prioridade #(.N(N)) u_busca (
    .vector (cand),
    .pointer(ptr_busca),
    .mode   (ROUND_ROBIN),
    .index  (sel),
    .found  (found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found)       state_next = PRESENT;
      PRESENT: if (hs && !found) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    valid  = (state == PRESENT);
    load_y = ((state == IDLE) && found) || (hs && found);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendentes <= '0;
      y         <= '0;
      ptr       <= '0;
      perdidos  <= '0;
    end else begin
      pendentes <= pend_next;
      if (load_y) y   <= sel;
      if (hs)     ptr <= y + W'(1);
      perdidos  <= (soma > 10'(PERDIDOS_MAX)) ? PERDIDOS_MAX : soma[7:0];
    end
  end

endmodule

// File: tb/tb_codificador_prioridade.sv
// Directed bench: fixed-priority and round-robin encoders against
// hand-computed codes, pending vectors and drop counts.
module tb_codificador_prioridade;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, ready;
  logic [7:0] d;
  logic [2:0] y;
  logic       valid;
  logic [7:0] pendentes, perdidos;

  logic       r_enable, r_ready;
  logic [7:0] r_d;
  logic [2:0] r_y;
  logic       r_valid;
  logic [7:0] r_pendentes, r_perdidos;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  codificador_prioridade #(.N(8), .ROUND_ROBIN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .d(d), .ready(ready),
    .y(y), .valid(valid), .pendentes(pendentes), .perdidos(perdidos)
  );

  codificador_prioridade #(.N(8), .ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .enable(r_enable), .d(r_d), .ready(r_ready),
    .y(r_y), .valid(r_valid), .pendentes(r_pendentes), .perdidos(r_perdidos)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; ready = 1'b0; d = '0;
    r_enable = 1'b0; r_ready = 1'b0; r_d = '0;
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_y", y, 0);
    chk("rst_pend", pendentes, 0);
    chk("rst_perd", perdidos, 0);
    rst_n = 1'b1;

    // Fixed priority: two requests, highest index first
    enable = 1'b1; d = 8'b0010_0100;
    step(); d = '0;
    chk("fp_capture_pend", pendentes, 8'h24);
    chk("fp_capture_valid", valid, 0);
    step();
    chk("fp_present_valid", valid, 1);
    chk("fp_present_y5", y, 5);
    ready = 1'b1;
    step();
    chk("fp_b2b_y2", y, 2);
    chk("fp_b2b_valid", valid, 1);
    step();
    chk("fp_drain_valid", valid, 0);
    chk("fp_drain_pend", pendentes, 0);
    ready = 1'b0;

    // Hold without preemption, then re-capture on the clearing bit
    d = 8'h08; step(); d = '0; step();
    chk("hold_y3", y, 3);
    d = 8'h80; step(); d = '0;
    chk("hold_no_preempt", y, 3);
    chk("hold_pend", pendentes, 8'h88);
    ready = 1'b1; d = 8'h08;
    step(); d = '0;
    chk("recap_y7", y, 7);
    chk("recap_pend", pendentes, 8'h88);
    chk("recap_no_drop", perdidos, 0);
    step();
    chk("recap_y3_again", y, 3);
    chk("recap_valid", valid, 1);
    step();
    chk("recap_idle", valid, 0);
    chk("recap_perd", perdidos, 0);

    // Enable gating, then a full 7..0 drain
    enable = 1'b0; d = 8'hFF;
    step(); step();
    chk("gate_pend", pendentes, 0);
    chk("gate_valid", valid, 0);
    enable = 1'b1;
    step(); enable = 1'b0; d = '0;
    chk("gate_capture", pendentes, 8'hFF);
    for (int i = 7; i >= 0; i--) begin
      step();
      chk($sformatf("drain_y%0d", i), y, i);
    end
    step();
    chk("drain_idle", valid, 0);
    chk("drain_pend", pendentes, 0);
    ready = 1'b0;

    // Drops against a held pending vector, then saturation
    enable = 1'b1; d = 8'h02;
    step();
    d = 8'hFF;
    step();
    chk("drop_1st", perdidos, 1);
    chk("drop_y1", y, 1);
    step();
    chk("drop_2nd", perdidos, 9);
    step();
    chk("drop_3rd", perdidos, 17);
    repeat (37) step();
    chk("drop_sat", perdidos, 255);
    chk("drop_hold_y", y, 1);

    // Asynchronous reset between edges while presenting
    d = '0; enable = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_y", y, 0);
    chk("arst_pend", pendentes, 0);
    chk("arst_perd", perdidos, 0);
    #2 rst_n = 1'b1;
    step(); step();
    chk("arst_stay_valid", valid, 0);
    chk("arst_stay_pend", pendentes, 0);

    // Round-robin with a continuously held request vector
    r_enable = 1'b1; r_ready = 1'b1; r_d = 8'b1000_0011;
    step();
    chk("rr_capture", r_pendentes, 8'h83);
    step(); chk("rr_y0_a", r_y, 0); chk("rr_valid", r_valid, 1);
    step(); chk("rr_y1_a", r_y, 1);
    step(); chk("rr_y7_a", r_y, 7);
    step(); chk("rr_y0_b", r_y, 0);
    step(); chk("rr_y1_b", r_y, 1);
    step(); chk("rr_y7_b", r_y, 7);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
